// File: rtl/eci_data_demux_pkg.sv
// Shared lynx platform constants used by the ECI read-data path.
// Sized so one request spans at most 32 data beats of 256 bits.
package lynxTypes;

    localparam int N_CHAN        = 3;
    localparam int N_CHAN_BITS   = 2;
    localparam int LEN_BITS      = 10;
    localparam int ECI_DATA_BITS = 256;

endpackage

// File: rtl/eci_data_demux_route.sv
// Combinational fan-out of the inbound ECI beat stream onto the channel picked by vfid,
// plus the matching tready mux back toward the inbound side.
module eci_data_demux_route
    import lynxTypes::*;
#(
    parameter int ARB_DATA_BITS = ECI_DATA_BITS
) (
    input  logic                                      active,
    input  logic [N_CHAN_BITS-1:0]                    vfid,
    input  logic                                      last,
    input  logic                                      in_tvalid,
    input  logic [ARB_DATA_BITS-1:0]                  in_tdata,
    input  logic [ARB_DATA_BITS/8-1:0]                in_tkeep,
    output logic                                      sel_tready,
    output logic [N_CHAN-1:0]                         out_tvalid,
    input  logic [N_CHAN-1:0]                         out_tready,
    output logic [N_CHAN-1:0][ARB_DATA_BITS-1:0]      out_tdata,
    output logic [N_CHAN-1:0][ARB_DATA_BITS/8-1:0]    out_tkeep,
    output logic [N_CHAN-1:0]                         out_tlast
);

    logic [N_CHAN-1:0] hit;

    generate
        for (genvar gi = 0; gi < N_CHAN; gi++) begin : g_chan
            assign hit[gi]        = active && (vfid == N_CHAN_BITS'(gi));
            assign out_tvalid[gi] = hit[gi] && in_tvalid;
            assign out_tdata[gi]  = in_tdata;
            assign out_tkeep[gi]  = in_tkeep;
            assign out_tlast[gi]  = hit[gi] && last;
        end
    endgenerate

    // Only the selected channel may push back on the inbound stream.
    assign sel_tready = |(hit & out_tready);

endmodule

// File: rtl/eci_data_demux.sv
// Steers inbound ECI read beats to the per-channel user stream named by each sequence
// entry, counting beats per entry and regenerating tlast at user-transfer boundaries.
module eci_data_demux
    import lynxTypes::*;
#(
    parameter int ARB_DATA_BITS = ECI_DATA_BITS,
    parameter int BEAT_LOG_BITS = $clog2(ARB_DATA_BITS/8),
    parameter int BLEN_BITS     = LEN_BITS - BEAT_LOG_BITS
) (
    input  logic                                      aclk,
    input  logic                                      aresetn,

    input  logic                                      mux_user_valid,
    output logic                                      mux_user_ready,
    input  logic                                      mux_user_ctl,
    input  logic [N_CHAN_BITS-1:0]                    mux_user_vfid,
    input  logic [BLEN_BITS-1:0]                      mux_user_len,

    input  logic                                      axis_in_tvalid,
    output logic                                      axis_in_tready,
    input  logic [ARB_DATA_BITS-1:0]                  axis_in_tdata,
    input  logic [ARB_DATA_BITS/8-1:0]                axis_in_tkeep,

    output logic [N_CHAN-1:0]                         axis_out_tvalid,
    input  logic [N_CHAN-1:0]                         axis_out_tready,
    output logic [N_CHAN-1:0][ARB_DATA_BITS-1:0]      axis_out_tdata,
    output logic [N_CHAN-1:0][ARB_DATA_BITS/8-1:0]    axis_out_tkeep,
    output logic [N_CHAN-1:0]                         axis_out_tlast
);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                 state;
    logic [BLEN_BITS-1:0]   cnt_r;
    logic [N_CHAN_BITS-1:0] vfid_r;
    logic                   ctl_r;

    logic sel_tready;
    logic beat;
    logic last_beat;
    logic take;

    assign axis_in_tready = (state == XFER) && sel_tready;
    assign beat           = axis_in_tvalid && axis_in_tready;
    assign last_beat      = beat && (cnt_r == '0);

    // Opening the entry port on the final beat lets the next request start without a bubble.
    assign mux_user_ready = (state == IDLE) || last_beat;
    assign take           = mux_user_valid && mux_user_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state  <= IDLE;
            cnt_r  <= '0;
            vfid_r <= '0;
            ctl_r  <= 1'b0;
        end else if (take) begin
            state  <= XFER;
            cnt_r  <= mux_user_len;
            vfid_r <= mux_user_vfid;
            ctl_r  <= mux_user_ctl;
        end else if (beat) begin
            if (cnt_r != '0) begin
                cnt_r <= cnt_r - 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

    eci_data_demux_route #(
        .ARB_DATA_BITS(ARB_DATA_BITS)
    ) u_route (
        .active     (state == XFER),
        .vfid       (vfid_r),
        .last       ((cnt_r == '0) && ctl_r),
        .in_tvalid  (axis_in_tvalid),
        .in_tdata   (axis_in_tdata),
        .in_tkeep   (axis_in_tkeep),
        .sel_tready (sel_tready),
        .out_tvalid (axis_out_tvalid),
        .out_tready (axis_out_tready),
        .out_tdata  (axis_out_tdata),
        .out_tkeep  (axis_out_tkeep),
        .out_tlast  (axis_out_tlast)
    );

endmodule

// File: tb/tb_eci_data_demux.sv
// Randomised scoreboard bench for eci_data_demux: independent drivers for entries, data
// and per-channel backpressure, with a monitor checking every delivered beat in order.
`timescale 1ns/1ps
module tb_eci_data_demux;
    import lynxTypes::*;

    localparam int DW   = ECI_DATA_BITS;
    localparam int KW   = DW/8;
    localparam int BLEN = LEN_BITS - $clog2(DW/8);
    localparam int CB   = N_CHAN_BITS;
    localparam int MAXB = 2**BLEN;

    logic aclk;
    logic aresetn;
    logic mux_user_valid, mux_user_ready, mux_user_ctl;
    logic [CB-1:0]   mux_user_vfid;
    logic [BLEN-1:0] mux_user_len;
    logic axis_in_tvalid, axis_in_tready;
    logic [DW-1:0] axis_in_tdata;
    logic [KW-1:0] axis_in_tkeep;
    logic [N_CHAN-1:0] axis_out_tvalid, axis_out_tready, axis_out_tlast;
    logic [N_CHAN-1:0][DW-1:0] axis_out_tdata;
    logic [N_CHAN-1:0][KW-1:0] axis_out_tkeep;

    typedef struct { logic ctl; logic [CB-1:0] vfid; logic [BLEN-1:0] len; } entry_t;
    typedef struct { logic [DW-1:0] data; logic [KW-1:0] keep; } beat_t;
    typedef struct { int ch; logic [DW-1:0] data; logic [KW-1:0] keep; logic last; } exp_t;

    entry_t mux_q[$];
    beat_t  dat_q[$];
    exp_t   exp_q[$];
    int     beat_cyc_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mux_prob = 100;
    int dat_prob = 100;
    int ready_mode = 0;
    bit hold_mux = 0;
    bit mux_hs = 0;
    bit dat_hs = 0;
    int beat_cnt = 0;
    int mux_hs_cyc = 0;
    logic tog;

    eci_data_demux dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .mux_user_valid  (mux_user_valid),
        .mux_user_ready  (mux_user_ready),
        .mux_user_ctl    (mux_user_ctl),
        .mux_user_vfid   (mux_user_vfid),
        .mux_user_len    (mux_user_len),
        .axis_in_tvalid  (axis_in_tvalid),
        .axis_in_tready  (axis_in_tready),
        .axis_in_tdata   (axis_in_tdata),
        .axis_in_tkeep   (axis_in_tkeep),
        .axis_out_tvalid (axis_out_tvalid),
        .axis_out_tready (axis_out_tready),
        .axis_out_tdata  (axis_out_tdata),
        .axis_out_tkeep  (axis_out_tkeep),
        .axis_out_tlast  (axis_out_tlast)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference model: a request of len+1 beats, tlast only on the final beat of a ctl=1 entry.
    task automatic push_req(input logic ctl, input int vfid, input int len);
        entry_t e;
        e.ctl  = ctl;
        e.vfid = vfid[CB-1:0];
        e.len  = len[BLEN-1:0];
        mux_q.push_back(e);
        for (int b = 0; b <= len; b++) begin
            beat_t d;
            exp_t  x;
            d.data = {8{$urandom()}};
            d.keep = $urandom();
            dat_q.push_back(d);
            x.ch   = vfid;
            x.data = d.data;
            x.keep = d.keep;
            x.last = ctl && (b == len);
            exp_q.push_back(x);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() > 0 || mux_q.size() > 0) && n < 5000) begin
            @(posedge aclk);
            n++;
        end
        chk({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge aclk);
    endtask

    // Entry driver
    initial begin
        entry_t e;
        mux_user_valid = 1'b0;
        mux_user_ctl   = 1'b0;
        mux_user_vfid  = '0;
        mux_user_len   = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                mux_user_valid = 1'b0;
            end else begin
                if (mux_hs) mux_user_valid = 1'b0;
                if (!mux_user_valid && !hold_mux && mux_q.size() > 0 &&
                    int'($urandom_range(99)) < mux_prob) begin
                    e = mux_q.pop_front();
                    mux_user_ctl   = e.ctl;
                    mux_user_vfid  = e.vfid;
                    mux_user_len   = e.len;
                    mux_user_valid = 1'b1;
                end
            end
        end
    end

    // Inbound data driver
    initial begin
        beat_t d;
        axis_in_tvalid = 1'b0;
        axis_in_tdata  = '0;
        axis_in_tkeep  = '0;
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                axis_in_tvalid = 1'b0;
            end else begin
                if (dat_hs) axis_in_tvalid = 1'b0;
                if (!axis_in_tvalid && dat_q.size() > 0 && int'($urandom_range(99)) < dat_prob) begin
                    d = dat_q.pop_front();
                    axis_in_tdata  = d.data;
                    axis_in_tkeep  = d.keep;
                    axis_in_tvalid = 1'b1;
                end
            end
        end
    end

    // Downstream backpressure driver
    initial begin
        tog = 1'b1;
        axis_out_tready = '1;
        forever begin
            @(posedge aclk);
            #1;
            tog = ~tog;
            for (int c = 0; c < N_CHAN; c++) begin
                case (ready_mode)
                    1:       axis_out_tready[c] = (int'($urandom_range(99)) < 70);
                    2:       axis_out_tready[c] = (c == 1) ? tog : 1'b1;
                    default: axis_out_tready[c] = 1'b1;
                endcase
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t x;
        forever begin
            @(negedge aclk);
            mux_hs = aresetn && mux_user_valid && mux_user_ready;
            dat_hs = aresetn && axis_in_tvalid && axis_in_tready;
            if (mux_hs) mux_hs_cyc = cyc;
            if (aresetn) begin
                if (mux_user_valid && int'(mux_user_vfid) >= N_CHAN)
                    chk("vfid_range", 64'(mux_user_vfid), 64'(N_CHAN - 1));
                if ($countones(axis_out_tvalid) > 1)
                    chk("onehot_tvalid", 64'(axis_out_tvalid), 64'd0);
                chk("in_out_handshake", 64'(dat_hs), 64'(|(axis_out_tvalid & axis_out_tready)));
                for (int c = 0; c < N_CHAN; c++) begin
                    if (axis_out_tvalid[c] && axis_out_tready[c]) begin
                        checks++;
                        beat_cnt++;
                        beat_cyc_q.push_back(cyc);
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_beat: ch=%0d data=%h with no beat outstanding", c, axis_out_tdata[c]);
                        end else begin
                            x = exp_q.pop_front();
                            if (x.ch != c || x.data !== axis_out_tdata[c] ||
                                x.keep !== axis_out_tkeep[c] || x.last !== axis_out_tlast[c]) begin
                                errors++;
                                $display("FAIL route: got ch=%0d data=%h keep=%h last=%b, expected ch=%0d data=%h keep=%h last=%b",
                                         c, axis_out_tdata[c], axis_out_tkeep[c], axis_out_tlast[c],
                                         x.ch, x.data, x.keep, x.last);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        int b0;
        int n;
        aresetn = 1'b0;
        repeat (4) @(posedge aclk);
        @(negedge aclk);
        chk("reset_mux_ready", 64'(mux_user_ready), 64'd1);
        chk("reset_in_tready", 64'(axis_in_tready), 64'd0);
        chk("reset_out_tvalid", 64'(axis_out_tvalid), 64'd0);
        @(posedge aclk);
        #1 aresetn = 1'b1;

        // Single entry onto channel 2
        b0 = beat_cnt;
        push_req(1'b1, 2, 3);
        drain("single");
        chk("single_beats", 64'(beat_cnt - b0), 64'd4);
        @(negedge aclk);
        chk("single_idle_ready", 64'(mux_user_ready), 64'd1);
        chk("single_idle_tready", 64'(axis_in_tready), 64'd0);

        // Back-to-back entries must stream without a bubble
        beat_cyc_q.delete();
        push_req(1'b0, 0, 0);
        push_req(1'b1, 1, 1);
        drain("b2b");
        chk("b2b_beats", 64'(beat_cyc_q.size()), 64'd3);
        if (beat_cyc_q.size() == 3)
            chk("b2b_cycles", 64'(beat_cyc_q[2] - beat_cyc_q[0]), 64'd2);

        // Data waiting while idle stays stalled until the entry arrives
        hold_mux = 1'b1;
        push_req(1'b1, 0, 2);
        @(posedge aclk);
        repeat (5) begin
            @(negedge aclk);
            chk("early_data_tvalid", 64'(axis_in_tvalid), 64'd1);
            chk("early_data_stall", 64'(axis_in_tready), 64'd0);
        end
        beat_cyc_q.delete();
        hold_mux = 1'b0;
        drain("early");
        if (beat_cyc_q.size() > 0)
            chk("early_first_latency", 64'(beat_cyc_q[0] - mux_hs_cyc), 64'd1);

        // Toggling backpressure on channel 1
        ready_mode = 2;
        b0 = beat_cnt;
        push_req(1'b0, 1, 7);
        drain("bp");
        chk("bp_beats", 64'(beat_cnt - b0), 64'd8);
        ready_mode = 0;

        // Maximum request length
        b0 = beat_cnt;
        push_req(1'b1, 0, MAXB - 1);
        drain("maxlen");
        chk("maxlen_beats", 64'(beat_cnt - b0), 64'(MAXB));

        // Reset after two of four beats
        b0 = beat_cnt;
        push_req(1'b1, 2, 3);
        n = 0;
        while (beat_cnt < b0 + 2 && n < 1000) begin
            @(posedge aclk);
            n++;
        end
        chk("midreset_wait_timeout", 64'(n >= 1000), 64'd0);
        #1 aresetn = 1'b0;
        exp_q.delete();
        dat_q.delete();
        mux_q.delete();
        @(posedge aclk);
        @(negedge aclk);
        chk("midreset_tvalid", 64'(axis_out_tvalid), 64'd0);
        chk("midreset_mux_ready", 64'(mux_user_ready), 64'd1);
        chk("midreset_in_tready", 64'(axis_in_tready), 64'd0);
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        b0 = beat_cnt;
        push_req(1'b1, 1, 2);
        drain("postreset");
        chk("postreset_beats", 64'(beat_cnt - b0), 64'd3);

        // Randomised traffic
        b0 = beat_cnt;
        n = 0;
        for (int i = 0; i < 48; i++) begin
            int len;
            if (i % 8 == 0) begin
                ready_mode = int'($urandom_range(1));
                mux_prob   = 40 + int'($urandom_range(60));
                dat_prob   = 40 + int'($urandom_range(60));
            end
            len = ($urandom_range(9) == 0) ? int'($urandom_range(MAXB - 1)) : int'($urandom_range(5));
            n += len + 1;
            push_req(1'($urandom_range(1)), int'($urandom_range(N_CHAN - 1)), len);
            if (i % 8 == 7) drain("random");
        end
        chk("random_beats", 64'(beat_cnt - b0), 64'(n));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eci_data_demux.md
# eci_data_demux

Read-data steering stage directly downstream of the ECI round-robin request arbiter. Pops one sequence entry (ctl, vfid, beat count) per granted request from the arbiter's multiplexing queue and routes the matching number of ECI data beats from the single inbound stream to the per-channel user stream selected by vfid. Regenerates user-side tlast from the sequence entry, because inbound ECI data carries no request boundaries.

## Interface
- ARB_DATA_BITS, default ECI_DATA_BITS: data beat width in bits.
- BEAT_LOG_BITS, default $clog2(ARB_DATA_BITS/8): derived; bytes-per-beat log2.
- BLEN_BITS, default LEN_BITS - BEAT_LOG_BITS: derived; width of the beat-count field.

- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- mux_user  muxIntf.m  1+N_CHAN_BITS+BLEN_BITS  sequence entries. Fields: valid/ready; ctl (1 = last request of a user transfer); vfid (target channel); len (beats - 1).
- axis_in  AXI4S.s  ARB_DATA_BITS data, /8 keep  inbound ECI data. tlast is ignored.
- axis_out[N_CHAN]  AXI4S.m  ARB_DATA_BITS data, /8 keep  per-channel user data.

## Operation
- State machine: IDLE, XFER.
- IDLE:
  - mux_user.ready = 1; axis_in.tready = 0.
  - On a mux_user handshake: latch vfid into vfid_r, len into cnt_r, ctl into ctl_r; go to XFER.
- XFER:
  - axis_in.tready = axis_out[vfid_r].tready.
  - axis_out[vfid_r].tvalid = axis_in.tvalid. tdata and tkeep pass through.
  - Every other axis_out tvalid = 0.
  - axis_out[vfid_r].tlast = (cnt_r == 0) && ctl_r.
- Beat accepted with cnt_r != 0: cnt_r decrements by 1.
- Beat accepted with cnt_r == 0 (last beat):
  - mux_user.ready = 1 in that same cycle.
  - If mux_user.valid: latch the new entry and stay in XFER. No bubble between requests.
  - Otherwise go to IDLE.
- Arithmetic:
  - cnt_r is BLEN_BITS wide and unsigned.
  - len = 0 means one beat; len = 2^BLEN_BITS-1 means the maximum.
  - cnt_r never wraps below 0.
- vfid outside 0..N_CHAN-1 is illegal; the arbiter guarantees it does not occur. The bench asserts on it.
- Data is never dropped or reordered. Beats belong to sequence entries in strict FIFO order.

## Timing
- Data path is combinational: zero latency from axis_in to axis_out. The only registers are state, cnt_r, vfid_r and ctl_r.
- mux_user.ready depends only on state, cnt_r, axis_in.tvalid and the selected tready. It does not depend on mux_user.valid.
- Reset values:
  - state = IDLE, cnt_r = 0, vfid_r = 0, ctl_r = 0.
  - All axis_out tvalid = 0, axis_in.tready = 0, mux_user.ready = 1.
- Reset mid-transfer: return to the reset values on the next edge. The remainder of the in-flight request is abandoned; upstream is reset together with this block.
- axis_in.tvalid while in IDLE: stalled (tready = 0) until a sequence entry arrives.
- Downstream backpressure on vfid_r stalls axis_in. Other channels do not influence it.
- Sustained throughput: 1 beat/cycle across request boundaries when entries are queued.

## Structure
- Shared package lynxTypes holds N_CHAN, N_CHAN_BITS, LEN_BITS and ECI_DATA_BITS. BLEN_BITS and BEAT_LOG_BITS stay local.
- The state enum is local to the module.
- No sub-module is required. Optionally add one axis_reg_slice per axis_out to break the combinational tready path; if used, it adds +1 cycle of latency and must still sustain 1 beat/cycle.

## Test plan
- Single entry (ctl=1, vfid=2, len=3), 4 beats D0..D3 -> axis_out[2] receives D0..D3, tlast on D3 only; other channels stay idle; back in IDLE after D3.
- Back-to-back entries (vfid=0, len=0, ctl=0) then (vfid=1, len=1, ctl=1), continuous tvalid -> 3 beats in 3 cycles: beat0 to ch0 with tlast=0, beats 1-2 to ch1 with tlast on beat 2.
- Data arrives before the entry (tvalid high for 5 cycles while in IDLE) -> tready=0 throughout; the first beat is accepted in the cycle after the mux handshake.
- Backpressure: axis_out[1].tready toggles 1010 during a len=7 request -> exactly 8 beats delivered in order, cnt_r reaches 0 exactly on the 8th beat.
- Max length len=2^BLEN_BITS-1 -> 2^BLEN_BITS beats routed with no counter wrap; tlast only on the final beat.
- aresetn asserted after 2 of 4 beats -> next cycle all tvalid = 0, state IDLE, mux_user.ready = 1; a fresh entry after reset routes correctly.
